// File: rtl/npu_done_pkg.sv
// npu_done_pkg: shared widths, FSM encoding and event modes for the done-flag writer
package npu_done_pkg;
   localparam int NPU_ADDR_W = 9;
   localparam int NPU_DATA_W = 8;
   localparam logic MODE_OVR = 1'b0;
   localparam logic MODE_OR = 1'b1;
   typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_RD, ST_CAP, ST_WR} state_t;
endpackage

// File: rtl/npu_done_fifo.sv
// npu_done_fifo: synchronous FIFO with fall-through head and full/empty flags
module npu_done_fifo #(
   parameter int W = 18,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = 1;
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   assign empty = wp == rp;
   assign full = wp == {~rp[AW], rp[AW-1:0]};
   assign dout = mem[rp[AW-1:0]];
   always_ff @(posedge clk)
      if (push) mem[wp[AW-1:0]] <= din;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + ONE;
         if (pop) rp <= rp + ONE;
      end
endmodule

// File: rtl/npu_done_writer.sv
// npu_done_writer: buffers NPU completion events and commits them to done-flag SRAM port 2
module npu_done_writer
   import npu_done_pkg::*;
#(
   parameter int ADDR_W = NPU_ADDR_W,
   parameter int DATA_W = NPU_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              evt_valid,
   output logic              evt_ready,
   input  logic [ADDR_W-1:0] evt_addr,
   input  logic [DATA_W-1:0] evt_flags,
   input  logic              evt_mode,
   input  logic              clear_req,
   output logic              busy,
   output logic [15:0]       evt_count,
   output logic [ADDR_W-1:0] sram_address,
   output logic              sram_chipselect,
   output logic              sram_write,
   output logic [DATA_W-1:0] sram_writedata,
   output logic              sram_clken,
   input  logic [DATA_W-1:0] sram_readdata
);
   localparam int EW = ADDR_W + DATA_W + 1;
   state_t state;
   logic fifo_full, fifo_empty, push, pop, clear_pend, live, h_mode;
   logic [EW-1:0] head;
   logic [ADDR_W-1:0] clr_addr, h_addr;
   logic [DATA_W-1:0] cur_flags, h_flags;
   assign {h_mode, h_addr, h_flags} = head;
   // live holds ready low for the first cycle out of reset even when no sweep runs
   assign evt_ready = live && !fifo_full && state != ST_CLEAR;
   assign push = evt_valid && evt_ready;
   assign pop = state == ST_IDLE && !clear_pend && !fifo_empty;
   assign busy = state != ST_IDLE || !fifo_empty;
   assign sram_clken = 1'b1;
   npu_done_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push),
      .din({evt_mode, evt_addr, evt_flags}),
      .pop(pop),
      .dout(head),
      .full(fifo_full),
      .empty(fifo_empty)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         live <= 1'b0;
         clear_pend <= 1'b0;
         clr_addr <= '0;
         cur_flags <= '0;
         evt_count <= '0;
         sram_address <= '0;
         sram_chipselect <= 1'b0;
         sram_write <= 1'b0;
         sram_writedata <= '0;
      end else begin
         live <= 1'b1;
         sram_chipselect <= 1'b0;
         sram_write <= 1'b0;
         clear_pend <= clear_req || (clear_pend && state != ST_IDLE);
         case (state)
            ST_CLEAR: begin
               sram_chipselect <= 1'b1;
               sram_write <= 1'b1;
               sram_address <= clr_addr;
               sram_writedata <= '0;
               clr_addr <= clr_addr + ADDR_W'(1);
               if (&clr_addr) state <= ST_IDLE;
            end
            ST_IDLE:
               if (clear_pend) begin
                  clr_addr <= '0;
                  state <= ST_CLEAR;
               end else if (!fifo_empty) begin
                  cur_flags <= h_flags;
                  sram_address <= h_addr;
                  sram_chipselect <= 1'b1;
                  sram_write <= h_mode != MODE_OR;
                  sram_writedata <= h_flags;
                  state <= h_mode == MODE_OR ? ST_RD : ST_WR;
               end
            ST_RD: state <= ST_CAP;
            ST_CAP: begin
               sram_chipselect <= 1'b1;
               sram_write <= 1'b1;
               sram_writedata <= sram_readdata | cur_flags;
               state <= ST_WR;
            end
            ST_WR: begin
               evt_count <= evt_count + 16'd1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
endmodule
